alu_arbiter: RTL and testbench

Shares the single ALU between two requesters: port 0 is calculator_core and port 1 is the output-path binary-to-BCD converter, which issues repeated divide-by-10 operations. It sits between the requesters and the alu instance, with valid/ready on every side. Only one operation is in flight at a time. Grant alternates round-robin, and the result is routed back only to the requester that issued the operation.

---
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared ALU: round-robin grant, one operation
// in flight, and the result is steered back only to the requester that issued it.
module alu_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*DATA_WIDTH-1:0] i_req_a,
    input  logic [2*DATA_WIDTH-1:0] i_req_b,
    input  logic [3:0]              i_req_op,
    input  logic [1:0]              i_req_signed,
    input  logic [1:0]              i_req_valid,
    output logic [1:0]              o_req_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_result,
    output logic                    o_rsp_error,
    output logic [1:0]              o_rsp_valid,
    input  logic [1:0]              i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_alu_input_a,
    output logic [DATA_WIDTH-1:0]   o_alu_input_b,
    output logic [1:0]              o_alu_input_op,
    output logic                    o_alu_input_signed,
    output logic                    o_alu_input_valid,
    input  logic                    i_alu_input_ready,
    input  logic [DATA_WIDTH-1:0]   i_alu_result,
    input  logic                    i_alu_error,
    input  logic                    i_alu_result_valid,
    output logic                    o_alu_result_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                  state_reg;
    logic                    owner_reg;
    logic                    last_grant_reg;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [1:0]              op_reg;
    logic                    signed_reg;

    logic                    winner;
    logic                    in_wait;
    logic [DATA_WIDTH-1:0]   req_a   [2];
    logic [DATA_WIDTH-1:0]   req_b   [2];
    logic [1:0]              req_op  [2];

    // Unpack the per-requester buses and build the per-requester handshake bits.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req_a[gi]  = i_req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_b[gi]  = i_req_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_op[gi] = i_req_op[gi*2 +: 2];
            // Ready is masked while reset is held so nothing appears granted.
            assign o_req_ready[gi] = rst_n && (state_reg == IDLE) &&
                                     i_req_valid[gi] && (winner == 1'(gi));
            assign o_rsp_valid[gi] = in_wait && (owner_reg == 1'(gi)) &&
                                     i_alu_result_valid;
        end
    endgenerate

    always_comb begin
        winner = 1'b0;
        if (i_req_valid == 2'b11) begin
            winner = ~last_grant_reg;
        end else if (i_req_valid[1]) begin
            winner = 1'b1;
        end
    end

    assign in_wait            = (state_reg == WAIT);
    assign o_rsp_result       = in_wait ? i_alu_result : '0;
    assign o_rsp_error        = in_wait && i_alu_error;
    assign o_alu_result_ready = in_wait && i_rsp_ready[owner_reg];

    assign o_alu_input_valid  = (state_reg == ISSUE);
    assign o_alu_input_a      = a_reg;
    assign o_alu_input_b      = b_reg;
    assign o_alu_input_op     = op_reg;
    assign o_alu_input_signed = signed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= '0;
            signed_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|o_req_ready) begin
                        a_reg      <= req_a[winner];
                        b_reg      <= req_b[winner];
                        op_reg     <= req_op[winner];
                        signed_reg <= i_req_signed[winner];
                        owner_reg  <= winner;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_alu_input_ready) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_alu_result_valid && i_rsp_ready[owner_reg]) begin
                        last_grant_reg <= owner_reg;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; the bench plays both requesters and the ALU.
module tb_alu_arbiter;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2*DW-1:0] i_req_a;
    logic [2*DW-1:0] i_req_b;
    logic [3:0]      i_req_op;
    logic [1:0]      i_req_signed;
    logic [1:0]      i_req_valid;
    logic [1:0]      o_req_ready;
    logic [DW-1:0]   o_rsp_result;
    logic            o_rsp_error;
    logic [1:0]      o_rsp_valid;
    logic [1:0]      i_rsp_ready;
    logic [DW-1:0]   o_alu_input_a;
    logic [DW-1:0]   o_alu_input_b;
    logic [1:0]      o_alu_input_op;
    logic            o_alu_input_signed;
    logic            o_alu_input_valid;
    logic            i_alu_input_ready;
    logic [DW-1:0]   i_alu_result;
    logic            i_alu_error;
    logic            i_alu_result_valid;
    logic            o_alu_result_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_req_a            (i_req_a),
        .i_req_b            (i_req_b),
        .i_req_op           (i_req_op),
        .i_req_signed       (i_req_signed),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .o_rsp_result       (o_rsp_result),
        .o_rsp_error        (o_rsp_error),
        .o_rsp_valid        (o_rsp_valid),
        .i_rsp_ready        (i_rsp_ready),
        .o_alu_input_a      (o_alu_input_a),
        .o_alu_input_b      (o_alu_input_b),
        .o_alu_input_op     (o_alu_input_op),
        .o_alu_input_signed (o_alu_input_signed),
        .o_alu_input_valid  (o_alu_input_valid),
        .i_alu_input_ready  (i_alu_input_ready),
        .i_alu_result       (i_alu_result),
        .i_alu_error        (i_alu_error),
        .i_alu_result_valid (i_alu_result_valid),
        .o_alu_result_ready (o_alu_result_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        i_req_a = '0; i_req_b = '0; i_req_op = '0; i_req_signed = '0;
        i_req_valid = '0; i_rsp_ready = '0; i_alu_input_ready = 1'b0;
        i_alu_result = '0; i_alu_error = 1'b0; i_alu_result_valid = 1'b0;
        rst_n = 1'b0;
        i_req_valid = 2'b01;
        step();
        @(negedge clk);
        check("rst_req_ready", 32'(o_req_ready), 32'h0);
        check("rst_alu_valid", 32'(o_alu_input_valid), 32'h0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
        check("rst_alu_a", 32'(o_alu_input_a), 32'h0);
        check("rst_alu_rdy", 32'(o_alu_result_ready), 32'h0);
        i_req_valid = 2'b00;
        step();
        rst_n = 1'b1;
        step();

        // Single add from requester 0
        i_req_a = {16'd0, 16'd7}; i_req_b = {16'd0, 16'd5}; i_req_op = 4'b0000;
        i_req_valid = 2'b01; i_alu_input_ready = 1'b1; i_rsp_ready = 2'b01;
        @(negedge clk);
        check("t1_req_ready", 32'(o_req_ready), 32'h1);
        step();
        i_req_valid = 2'b00;
        @(negedge clk);
        check("t1_alu_valid", 32'(o_alu_input_valid), 32'h1);
        check("t1_alu_a", 32'(o_alu_input_a), 32'd7);
        check("t1_alu_b", 32'(o_alu_input_b), 32'd5);
        step();
        i_alu_result = 16'd12; i_alu_result_valid = 1'b1;
        @(negedge clk);
        check("t1_rsp_valid", 32'(o_rsp_valid), 32'h1);
        check("t1_rsp_result", 32'(o_rsp_result), 32'd12);
        check("t1_alu_rdy", 32'(o_alu_result_ready), 32'h1);
        step();
        i_alu_result_valid = 1'b0;
        @(negedge clk);
        check("t1_idle_rsp", 32'(o_rsp_valid), 32'h0);
        check("t1_idle_alu_valid", 32'(o_alu_input_valid), 32'h0);
        $display("op single owner=0 result=%0d", o_rsp_result);

        // Contention from reset: requester 0 wins first, then strict alternation
        do_reset();
        i_req_a = {16'd200, 16'd100}; i_req_b = {16'd10, 16'd10}; i_req_op = 4'b1111;
        i_req_valid = 2'b11; i_rsp_ready = 2'b11; i_alu_input_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [1:0]    exp_oh;
            logic [DW-1:0] exp_a;
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_a  = (k % 2 == 0) ? 16'd100 : 16'd200;
            @(negedge clk);
            check("rr_req_ready", 32'(o_req_ready), 32'(exp_oh));
            step();
            @(negedge clk);
            check("rr_alu_a", 32'(o_alu_input_a), 32'(exp_a));
            check("rr_req_ready_busy", 32'(o_req_ready), 32'h0);
            step();
            i_alu_result = exp_a / 16'd10; i_alu_result_valid = 1'b1;
            @(negedge clk);
            check("rr_rsp_valid", 32'(o_rsp_valid), 32'(exp_oh));
            check("rr_rsp_result", 32'(o_rsp_result), 32'(exp_a / 16'd10));
            $display("op rr %0d owner_oh=%b result=%0d", k, o_rsp_valid, o_rsp_result);
            step();
            i_alu_result_valid = 1'b0;
        end
        i_req_valid = 2'b00;
        step();

        // Back-pressure: ALU command stall, then owner response stall
        i_req_a = {16'hdead, 16'h1234}; i_req_b = {16'hbeef, 16'h0056}; i_req_op = 4'b1001;
        i_req_signed = 2'b01; i_req_valid = 2'b01; i_alu_input_ready = 1'b0; i_rsp_ready = 2'b10;
        @(negedge clk);
        check("bp_req_ready", 32'(o_req_ready), 32'h1);
        step();
        i_req_valid = 2'b00; i_req_a = '1; i_req_b = '1; i_req_op = '0; i_req_signed = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_alu_valid", 32'(o_alu_input_valid), 32'h1);
            check("bp_alu_ab", {o_alu_input_a, o_alu_input_b}, 32'h1234_0056);
            check("bp_alu_op_sg", {29'd0, o_alu_input_op, o_alu_input_signed}, 32'h3);
            step();
        end
        i_alu_input_ready = 1'b1;
        @(negedge clk);
        check("bp_alu_valid_acc", 32'(o_alu_input_valid), 32'h1);
        step();
        i_alu_input_ready = 1'b0;
        i_alu_result = 16'h128a; i_alu_result_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_rsp_valid_stall", 32'(o_rsp_valid), 32'h1);
            check("bp_alu_rdy_stall", 32'(o_alu_result_ready), 32'h0);
            step();
        end
        i_rsp_ready = 2'b01;
        @(negedge clk);
        check("bp_alu_rdy", 32'(o_alu_result_ready), 32'h1);
        check("bp_rsp_result", 32'(o_rsp_result), 32'h128a);
        $display("op backpressure owner=0 result=%0h", o_rsp_result);
        step();
        @(negedge clk);
        check("bp_no_dup", 32'(o_rsp_valid), 32'h0);
        i_alu_result_valid = 1'b0;
        step();

        // Error pass-through on requester 1, then requester 0 is served
        i_req_a = {16'd9, 16'd0}; i_req_b = {16'd0, 16'd0}; i_req_op = 4'b1100;
        i_req_valid = 2'b10; i_alu_input_ready = 1'b1; i_rsp_ready = 2'b10;
        @(negedge clk);
        check("err_req_ready", 32'(o_req_ready), 32'h2);
        step();
        i_req_valid = 2'b00;
        @(negedge clk);
        check("err_alu_a", 32'(o_alu_input_a), 32'd9);
        step();
        i_alu_result = 16'hffff; i_alu_error = 1'b1; i_alu_result_valid = 1'b1;
        @(negedge clk);
        check("err_rsp_valid", 32'(o_rsp_valid), 32'h2);
        check("err_rsp_error", 32'(o_rsp_error), 32'h1);
        $display("op error owner=1 error=%0d", o_rsp_error);
        step();
        i_alu_result_valid = 1'b0; i_alu_error = 1'b0;
        i_req_a = {16'd0, 16'd33}; i_req_valid = 2'b01; i_rsp_ready = 2'b00;
        @(negedge clk);
        check("err_next_req_ready", 32'(o_req_ready), 32'h1);
        step();
        i_req_valid = 2'b00;
        @(negedge clk);
        check("err_next_alu_a", 32'(o_alu_input_a), 32'd33);
        step();

        // Reset while awaiting the result
        i_alu_result = 16'd77; i_alu_result_valid = 1'b1;
        @(negedge clk);
        check("mr_wait_rsp", 32'(o_rsp_valid), 32'h1);
        #1;
        rst_n = 1'b0; i_req_valid = 2'b11;
        #1;
        check("mr_rsp_valid", 32'(o_rsp_valid), 32'h0);
        check("mr_alu_rdy", 32'(o_alu_result_ready), 32'h0);
        check("mr_req_ready", 32'(o_req_ready), 32'h0);
        check("mr_alu_a", 32'(o_alu_input_a), 32'h0);
        check("mr_rsp_result", 32'(o_rsp_result), 32'h0);
        step();
        rst_n = 1'b1; i_alu_result_valid = 1'b0;
        @(negedge clk);
        check("mr_first_grant", 32'(o_req_ready), 32'h1);
        $display("op reset-abort regrant=%b", o_req_ready);
        i_req_valid = 2'b00;
        do_reset();

        // Spurious ALU result while idle
        i_alu_result = 16'd55; i_alu_result_valid = 1'b1; i_rsp_ready = 2'b11;
        @(negedge clk);
        check("sp_alu_rdy", 32'(o_alu_result_ready), 32'h0);
        check("sp_rsp_valid", 32'(o_rsp_valid), 32'h0);
        step();
        i_alu_result_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
